program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time program loader upstream of RISCV_Processor.
//  Accepts a byte stream (valid/ready) carrying a length header and program words.
//  Assembles little-endian 32-bit words and writes them into instruction memory.
//  Holds the core in reset (cpu_reset=1) until the whole image is written, then releases it.
// PARAMETERS
//  ADDR_WIDTH  32  width of imem_addr (byte address)
//  MEM_DEPTH   256 instruction memory capacity in 32-bit words; max accepted length
//  BASE_ADDR   0   byte address of word 0; word i is written at BASE_ADDR + 4*i
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  start         in   1   1-cycle pulse; begins a load from IDLE, DONE or ERR
//  byte_in       in   8   stream data byte
//  byte_valid    in   1   byte_in valid
//  byte_ready    out  1   loader can accept; a byte transfers when byte_valid && byte_ready
//  imem_we       out  1   instruction memory write enable, 1-cycle pulse per word
//  imem_addr     out  ADDR_WIDTH  write byte address
//  imem_wdata    out  32  write data
//  cpu_reset     out  1   active-high reset to RISCV_Processor
//  done          out  1   image loaded, core running
//  error         out  1   bad length header
//  words_loaded  out  16  count of words written in current load
// BEHAVIOUR
//  Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   done=0, error=0, words_loaded=0, state=IDLE. All outputs registered.
//  Stream format: LEN[7:0], LEN[15:8], then 4*LEN bytes; each word is sent LSB first.
//  FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
//   IDLE:   cpu_reset=1, byte_ready=0; start -> LEN_LO (words_loaded<=0, done<=0, error<=0).
//   LEN_LO: byte_ready=1; on transfer latch LEN[7:0] -> LEN_HI.
//   LEN_HI: byte_ready=1; on transfer latch LEN[15:8];
//     if LEN==0 or LEN>MEM_DEPTH -> ERR, else -> DATA with byte index 0.
//   DATA:   byte_ready=1; byte k (0..3) stored into wdata[8k+7:8k];
//     on 4th transfer -> WRITE.
//   WRITE:  byte_ready=0; imem_we=1 for exactly one cycle;
//     imem_addr=BASE_ADDR+4*words_loaded; words_loaded increments at end of cycle.
//     If the incremented count==LEN -> DONE, else -> DATA.
//   DONE:   done=1, cpu_reset=0 (first cycle after the final WRITE); byte_ready=0.
//     start -> LEN_LO, cpu_reset returns to 1 the same edge.
//   ERR:    error=1, cpu_reset=1, byte_ready=0; start -> LEN_LO.
//  Latency: the 4th byte transfer at edge n gives imem_we high in cycle n+1.
//   cpu_reset falls one cycle after the final imem_we.
//  Throughput: one word per 5 cycles with byte_valid held high.
//  byte_valid low stalls in place; no state or index change without a transfer.
//  Bytes offered while byte_ready=0 are not consumed.
//  start: ignored in LEN_LO, LEN_HI, DATA, WRITE (no restart mid-load).
//  reset mid-operation: immediate return to IDLE with reset values.
//   Words already written stay in memory; the next load rewrites from BASE_ADDR.
//  Address arithmetic is ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH.
//   LEN<=MEM_DEPTH guarantees no overrun.
// TESTING
//  1. Assert reset low mid-cycle (async) -> outputs at reset values before the next clk edge;
//     cpu_reset=1.
//  2. start; stream 02 00 13 00 00 00 93 00 10 00 ->
//     write 0x00000013 @BASE_ADDR, then 0x00100093 @BASE_ADDR+4;
//     words_loaded=2, done=1, cpu_reset=0.
//  3. Same stream with byte_valid toggled every other cycle ->
//     identical writes, exactly 2 imem_we pulses, no duplicated bytes.
//  4. Header 00 00 -> error=1, no imem_we.
//     Header 01 01 (257) with MEM_DEPTH=256 -> error=1, cpu_reset=1.
//  5. Pull reset low after 5 data bytes -> IDLE, cpu_reset=1.
//     A full 1-word reload (01 00 EF BE AD DE) -> 0xDEADBEEF @BASE_ADDR.
//  6. Pulse start mid-DATA -> ignored, load completes.
//     Pulse start in DONE -> cpu_reset=1, done=0, new header accepted.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: length header + little-endian words from a byte
// stream into instruction memory, holding the core in reset until complete.
module program_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [1:0]              idx_q, idx_d;
    logic                    byte_ready_q, byte_ready_d;
    logic                    imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]             imem_wdata_q, imem_wdata_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [15:0]             words_loaded_q, words_loaded_d;

    logic                    xfer;
    logic [15:0]             full_len;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign xfer      = byte_valid && byte_ready_q;
    assign full_len  = {byte_in, len_q[7:0]};
    assign word_addr = BASE_ADDR
                     + ADDR_WIDTH'(32'(words_loaded_q) << 2);

    // Next-state, datapath updates and registered output values
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d        = LEN_LO;
                    words_loaded_d = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_in;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = full_len;
                    idx_d = '0;
                    if (full_len == 16'd0 || int'(full_len) > MEM_DEPTH)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    imem_wdata_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = WRITE;
                        imem_addr_d = word_addr;
                    end
                end
            end
            WRITE: begin
                words_loaded_d = words_loaded_q + 16'd1;
                if (words_loaded_d == len_q)
                    state_d = DONE;
                else
                    state_d = DATA;
            end
            default: state_d = IDLE;
        endcase

        byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI)
                    || (state_d == DATA);
        imem_we_d    = (state_d == WRITE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
        cpu_reset_d  = (state_d != DONE);
    end

    // State and output registers; async reset parks the core in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            byte_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            byte_ready_q   <= byte_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
